// File: rtl/ps2_pad_ctrl.sv
// ps2_pad_ctrl: autonomous DualShock-style PS2 pad poller with frame validation.
// Define PS2_RUMBLE_EN to add the motor_small/motor_large rumble inputs.
module ps2_pad_ctrl #(
  parameter int HALF_BIT_CYC = 240,
  parameter int SETUP_HALF   = 2,
  parameter int GAP_HALF     = 2,
  parameter int HOLD_HALF    = 2,
  parameter int POLL_CYC     = 800000
) (
  input  logic        CLK_40M,
  input  logic        rst,
  input  logic        di,
  input  logic        poll_now,
`ifdef PS2_RUMBLE_EN
  input  logic        motor_small,
  input  logic [7:0]  motor_large,
`endif
  output logic        sdo,
  output logic        sclk,
  output logic        scs,
  output logic [15:0] buttons,
  output logic [7:0]  data_r_x,
  output logic [7:0]  data_r_y,
  output logic [7:0]  data_l_x,
  output logic [7:0]  data_l_y,
  output logic [7:0]  pad_id,
  output logic        pad_present,
  output logic        frame_valid,
  output logic        busy
);

  localparam int HW = $clog2(HALF_BIT_CYC);
  localparam int PW = $clog2(POLL_CYC);
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_BIT_CYC - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYC - 1);
  localparam logic [7:0]    SETUP_LAST = 8'(SETUP_HALF - 1);
  localparam logic [7:0]    GAP_LAST   = 8'(GAP_HALF - 1);
  localparam logic [7:0]    HOLD_LAST  = 8'(HOLD_HALF - 1);
  localparam logic [3:0]    LAST_BYTE  = 4'd8;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD} state_t;

  state_t          state;
  logic [HW-1:0]   half_cnt;
  logic [PW-1:0]   poll_cnt;
  logic [7:0]      ph_cnt;
  logic [3:0]      byte_idx;
  logic [8:1][7:0] rx;
  logic [7:0]      tx_byte;
  logic            done;
  logic            tick, poll_exp, start, frame_ok;

`ifdef PS2_RUMBLE_EN
  logic            motor_small_q;
  logic [7:0]      motor_large_q;
`endif

  assign tick     = (half_cnt == HALF_LAST);
  assign poll_exp = (poll_cnt == POLL_LAST);
  assign start    = (state == IDLE) && (poll_exp || poll_now);
  assign frame_ok = (rx[2] == 8'h5A) && ((rx[1] == 8'h41) || (rx[1] == 8'h73));

  always_comb begin
    tx_byte = 8'h00;
    case (byte_idx)
      4'd0: tx_byte = 8'h01;
      4'd1: tx_byte = 8'h42;
`ifdef PS2_RUMBLE_EN
      4'd3: tx_byte = {7'b0, motor_small_q};
      4'd4: tx_byte = motor_large_q;
`endif
      default: tx_byte = 8'h00;
    endcase
  end

  // Half-period timebase; realigned to each frame start so ticks are frame-relative.
  always_ff @(posedge CLK_40M or posedge rst) begin
    if (rst)               half_cnt <= '0;
    else if (start || tick) half_cnt <= '0;
    else                   half_cnt <= half_cnt + 1'b1;
  end

  always_ff @(posedge CLK_40M or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      poll_cnt    <= '0;
      ph_cnt      <= '0;
      byte_idx    <= '0;
      rx          <= '0;
      done        <= 1'b0;
      scs         <= 1'b1;
      sclk        <= 1'b1;
      sdo         <= 1'b1;
      busy        <= 1'b0;
      buttons     <= 16'h0000;
      data_r_x    <= 8'h80;
      data_r_y    <= 8'h80;
      data_l_x    <= 8'h80;
      data_l_y    <= 8'h80;
      pad_id      <= 8'h00;
      pad_present <= 1'b0;
      frame_valid <= 1'b0;
`ifdef PS2_RUMBLE_EN
      motor_small_q <= 1'b0;
      motor_large_q <= 8'h00;
`endif
    end else begin
      done        <= 1'b0;
      frame_valid <= 1'b0;
      poll_cnt    <= poll_exp ? '0 : poll_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= SETUP;
            scs      <= 1'b0;
            busy     <= 1'b1;
            byte_idx <= '0;
            ph_cnt   <= '0;
            poll_cnt <= '0;
`ifdef PS2_RUMBLE_EN
            motor_small_q <= motor_small;
            motor_large_q <= motor_large;
`endif
          end
        end
        SETUP: begin
          if (tick) begin
            if (ph_cnt == SETUP_LAST) begin
              state  <= SHIFT;
              ph_cnt <= '0;
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
            end
          end
        end
        SHIFT: begin
          if (tick) begin
            // Even ticks drive CMD on the falling edge, odd ticks sample DAT on the rise.
            if (!ph_cnt[0]) begin
              sclk <= 1'b0;
              sdo  <= tx_byte[ph_cnt[3:1]];
            end else begin
              sclk <= 1'b1;
              if (byte_idx != 4'd0) rx[byte_idx][ph_cnt[3:1]] <= di;
            end
            if (ph_cnt == 8'd15) begin
              ph_cnt <= '0;
              state  <= (byte_idx < LAST_BYTE) ? GAP : HOLD;
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (ph_cnt == GAP_LAST) begin
              state    <= SHIFT;
              ph_cnt   <= '0;
              byte_idx <= byte_idx + 1'b1;
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            if (ph_cnt == HOLD_LAST) begin
              state  <= IDLE;
              ph_cnt <= '0;
              scs    <= 1'b1;
              sclk   <= 1'b1;
              sdo    <= 1'b1;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Commit the captured frame one cycle after ATT releases.
      if (done) begin
        pad_id      <= rx[1];
        pad_present <= frame_ok;
        frame_valid <= frame_ok;
        if (frame_ok) begin
          buttons <= ~{rx[4], rx[3]};
          if (rx[1] == 8'h73) begin
            data_r_x <= rx[5];
            data_r_y <= rx[6];
            data_l_x <= rx[7];
            data_l_y <= rx[8];
          end else begin
            data_r_x <= 8'h80;
            data_r_y <= 8'h80;
            data_l_x <= 8'h80;
            data_l_y <= 8'h80;
          end
        end
      end
    end
  end

endmodule
